mod_mult: RTL and testbench
===========================

MOD_MULT -- requirements
Module: mod_mult

Interface
REQ-001 SHALL have parameter P_WIDTH, default P_WIDTH from elliptic_curve_structs (256), operand/result width.
REQ-002 SHALL have parameter MODULUS, default P from elliptic_curve_structs (secp256k1 field prime), reduction modulus.
REQ-003 SHALL have port Clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port a  input  P_WIDTH  multiplicand, latched on accepted Start.
REQ-007 SHALL have port b  input  P_WIDTH  multiplier, latched on accepted Start.
REQ-008 SHALL have port product  output  P_WIDTH  (a*b) mod MODULUS, registered.
REQ-009 SHALL have port Busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port Done  output  1  one-cycle pulse marking product valid.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-012 SHALL accept Start=1 in IDLE by: latching a and b; clearing acc; setting bit counter to P_WIDTH-1; moving to RUN.
REQ-013 SHALL, each RUN cycle, process b bit [cnt], MSB first: acc <- 2*acc mod MODULUS, then acc <- acc + a mod MODULUS when the bit is 1.
REQ-014 SHALL perform each mod step as at most one conditional subtraction of MODULUS, with a P_WIDTH+2-bit internal datapath so no carry is lost.
REQ-015 SHALL move RUN -> DONE after the cycle processing bit 0, i.e. RUN lasts exactly P_WIDTH cycles.
REQ-016 SHALL in DONE: load product from acc, assert Done for exactly one cycle, and return to IDLE on the next edge.
REQ-017 SHALL give latency: Done is high P_WIDTH+1 cycles after the edge that accepted Start, and product is valid in that cycle.
REQ-018 SHALL hold product stable from Done until the next accepted Start's DONE cycle.
REQ-019 SHALL ignore Start while in RUN or DONE, with no queuing.
REQ-020 SHALL accept a Start in the cycle immediately after DONE (back-to-back throughput P_WIDTH+2 cycles).
REQ-021 SHALL ignore changes on a and b after Start is accepted.
REQ-022 SHALL produce product 0 when either operand is 0, and SHALL keep full latency in that case.

Reset
REQ-023 SHALL, on Reset low at any time including mid-RUN, asynchronously force state IDLE, Done=0, Busy=0, product=0, acc=0, counter=0.
REQ-024 SHALL abandon any in-flight operation on Reset with no Done pulse, and accept the first Start after Reset deasserts.

Configuration
REQ-025 SHALL, with MOD_MULT_INPUT_REDUCE_EN defined, subtract MODULUS once from each latched operand that is >= MODULUS at Start acceptance, covering all P_WIDTH-bit inputs since 2*MODULUS > 2^P_WIDTH, with no added latency.
REQ-026 SHALL, without MOD_MULT_INPUT_REDUCE_EN, latch operands unmodified; operands >= MODULUS are then a caller error with unspecified product, and timing is unchanged.

Verification
REQ-027 SHALL cover: a=3, b=5, Start pulse -> Done exactly P_WIDTH+1 cycles later, product=15, Busy low the next cycle.
REQ-028 SHALL cover: a=MODULUS-1, b=MODULUS-1 -> product=1; and a=MODULUS-1, b=2 -> product=MODULUS-2.
REQ-029 SHALL cover: a=0, b=any -> product=0 with full latency; Start reasserted mid-RUN with a=7 -> ignored, product matches the first operands.
REQ-030 SHALL cover: Reset low at RUN cycle 100 -> Done, Busy and product all 0, no Done pulse; a new Start with a=2, b=9 -> product=18.
REQ-031 SHALL cover: two back-to-back operations, with Start asserted the cycle after Done -> both products correct, and each Done is a one-cycle pulse.
REQ-032 SHALL cover, with MOD_MULT_INPUT_REDUCE_EN defined: a=MODULUS+2, b=3 -> product=6.

Source files
------------

// File: rtl/mod_mult.sv
// mod_mult: MSB-first interleaved modular multiplier, product = (a*b) mod MODULUS after P_WIDTH+1 cycles.
// Define MOD_MULT_INPUT_REDUCE_EN to fold operands >= MODULUS back into range when Start is accepted.
module mod_mult #(
  parameter int P_WIDTH = 256,
  parameter logic [P_WIDTH-1:0] MODULUS =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [P_WIDTH-1:0] a,
  input  logic [P_WIDTH-1:0] b,
  output logic [P_WIDTH-1:0] product,
  output logic               Busy,
  output logic               Done
);
  localparam int CW = P_WIDTH > 1 ? $clog2(P_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [P_WIDTH-1:0] r_a, r_b, r_acc, w_a_in, w_b_in, w_acc_nxt;
  logic [CW-1:0] r_cnt;
  logic [P_WIDTH+1:0] w_mod, w_dbl, w_dbl_r, w_sum;
`ifdef MOD_MULT_INPUT_REDUCE_EN
  // 2*MODULUS > 2^P_WIDTH, so one subtraction always lands in range
  assign w_a_in = (a >= MODULUS) ? a - MODULUS : a;
  assign w_b_in = (b >= MODULUS) ? b - MODULUS : b;
`else
  assign w_a_in = a;
  assign w_b_in = b;
`endif
  // two guard bits keep the doubled-plus-added value carry-free
  assign w_mod     = {2'b00, MODULUS};
  assign w_dbl     = {1'b0, r_acc, 1'b0};
  assign w_dbl_r   = (w_dbl >= w_mod) ? w_dbl - w_mod : w_dbl;
  assign w_sum     = w_dbl_r + (r_b[r_cnt] ? {2'b00, r_a} : '0);
  assign w_acc_nxt = P_WIDTH'((w_sum >= w_mod) ? w_sum - w_mod : w_sum);
  assign Busy      = r_state != IDLE;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (Start ? RUN : IDLE) :
             (r_state == RUN)  ? ((r_cnt == '0) ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      product <= '0;
      Done    <= 1'b0;
    end else begin
      r_state <= w_next;
      Done    <= r_state == DONE;
      if (r_state == IDLE && Start) begin
        r_a   <= w_a_in;
        r_b   <= w_b_in;
        r_acc <= '0;
        r_cnt <= CW'(P_WIDTH - 1);
      end else if (r_state == RUN) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == DONE) product <= r_acc;
    end
  end
endmodule

// File: tb/tb_mod_mult.sv
// tb_mod_mult: randomized scoreboard bench for mod_mult against a wide-arithmetic reference.
module tb_mod_mult;
  localparam int P = 256;
  localparam logic [P-1:0] M =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  typedef struct {logic [P-1:0] p; int due;} exp_t;
  logic Clk = 0, Reset = 0, Start = 0, Busy, Done;
  logic [P-1:0] a = '0, b = '0, product;
  exp_t exp_q[$];
  int cyc = 0, n_chk = 0, n_pass = 0;
  logic [P-1:0] held = '0;
  logic prev_done = 0;

  mod_mult dut (.Clk(Clk), .Reset(Reset), .Start(Start), .a(a), .b(b),
                .product(product), .Busy(Busy), .Done(Done));

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic check(input bit ok, input string nm, input logic [P-1:0] act, input logic [P-1:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  function automatic logic [P-1:0] ref_mul(input logic [P-1:0] x, input logic [P-1:0] y);
    logic [2*P-1:0] r;
    r = ({{P{1'b0}}, x} * {{P{1'b0}}, y}) % {{P{1'b0}}, M};
    return r[P-1:0];
  endfunction

  function automatic logic [P-1:0] rnd();
    logic [P-1:0] v;
    do v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    while (v >= M);
    return v;
  endfunction

  always @(negedge Clk) begin
    if (!Reset) held = '0;
    else if (Done) begin
      check(!Busy, "busy_in_done", P'(Busy), '0);
      check(!prev_done, "done_pulse", P'(prev_done), '0);
      if (exp_q.size() == 0) check(0, "unexpected_done", P'(Done), '0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check(product == e.p, "product", product, e.p);
        check(cyc == e.due, "latency", P'(cyc), P'(e.due));
      end
      held = product;
    end else check(product == held, "product_hold", product, held);
    prev_done = Done;
  end

  // call at a negedge with the DUT idle; returns just after the accepting edge
  task automatic start_op(input logic [P-1:0] x, input logic [P-1:0] y);
    Start = 1; a = x; b = y;
    @(posedge Clk); #1;
    exp_q.push_back('{ref_mul(x, y), cyc + P + 1});
    Start = 0; a = rnd(); b = rnd();
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge Clk);
      seen = Done;
    end
    if (!seen) check(0, "timeout", '0, P'(1));
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check(Done == 0, "rst_done", P'(Done), '0);
    check(Busy == 0, "rst_busy", P'(Busy), '0);
    check(product == '0, "rst_product", product, '0);
    Reset = 1;
    @(negedge Clk);
    start_op(3, 5);
    @(negedge Clk);
    check(Busy == 1, "busy_run", P'(Busy), P'(1));
    wait_done();
    @(negedge Clk); start_op(M - 1, M - 1); @(negedge Clk); wait_done();
    @(negedge Clk); start_op(M - 1, 2); @(negedge Clk); wait_done();
    @(negedge Clk); start_op(0, rnd()); @(negedge Clk); wait_done();
    @(negedge Clk); start_op(rnd(), 0); @(negedge Clk); wait_done();
    @(negedge Clk); start_op(rnd(), rnd());
    repeat (50) @(negedge Clk);
    Start = 1; a = 7; b = rnd();
    repeat (3) @(negedge Clk);
    Start = 0;
    wait_done();
    @(negedge Clk); start_op(rnd(), rnd());
    repeat (100) @(negedge Clk);
    Reset = 0;
    #1;
    check(Done == 0, "rst_mid_done", P'(Done), '0);
    check(Busy == 0, "rst_mid_busy", P'(Busy), '0);
    check(product == '0, "rst_mid_product", product, '0);
    exp_q.delete();
    @(negedge Clk); Reset = 1;
    repeat (300) @(negedge Clk);
    start_op(2, 9); @(negedge Clk); wait_done();
    for (int i = 0; i < 4; i++) begin
      start_op(rnd(), rnd());
      wait_done();
    end
`ifdef MOD_MULT_INPUT_REDUCE_EN
    @(negedge Clk); start_op(M + 2, 3); @(negedge Clk); wait_done();
`endif
    repeat (5) @(negedge Clk);
    check(exp_q.size() == 0, "queue_empty", P'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
